// File: rtl/servo_ramp_if.sv
// rtl/servo_ramp_if.sv - target command handshake between host and servo_ramp
interface servo_ramp_if;
    logic        cmd_valid;
    logic [12:0] cmd_target;
    logic        cmd_ready;

    modport master (output cmd_valid, output cmd_target, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/servo_ramp.sv
// rtl/servo_ramp.sv - slew-rate limiter stepping servo magnitude toward a clamped target
module servo_ramp #(
    parameter int CLK_HZ    = 50000000,
    parameter int UPDATE_HZ = 1000,
    parameter int MAG_MIN   = 0,
    parameter int MAG_MAX   = 8191,
    parameter int INIT_MAG  = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    servo_ramp_if.slave  cmd,
    input  logic [5:0]   step_i,
    input  logic         hold_i,
    output logic [12:0]  magnitude_o,
    output logic         busy_o,
    output logic         at_target_o,
    output logic         clamped_o
);
    localparam int          DIV   = CLK_HZ / UPDATE_HZ;
    localparam int          CW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [12:0] MIN13  = 13'(MAG_MIN);
    localparam logic [12:0] MAX13  = 13'(MAG_MAX);
    localparam logic [12:0] INIT13 = 13'(INIT_MAG);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [12:0]   target_q, target_d;
    logic [12:0]   mag_q, mag_d;
    logic [0:0]    state_q, state_d;
    logic          ready_q;
    logic          clamped_q, clamped_d;

    logic               tick;
    logic               accept;
    logic [12:0]        cmd_clamped;
    logic signed [13:0] diff;
    logic [13:0]        adiff;
    logic [5:0]         s;

    assign tick   = (cnt_q == LAST);
    assign accept = cmd.cmd_valid & ready_q;

    // t < MIN written as t+1 <= MIN so a zero minimum does not fold to a constant compare
    always_comb begin
        cmd_clamped = cmd.cmd_target;
        if (({1'b0, cmd.cmd_target} + 14'd1) <= {1'b0, MIN13})
            cmd_clamped = MIN13;
        else if ({1'b0, cmd.cmd_target} > {1'b0, MAX13})
            cmd_clamped = MAX13;
    end

    assign diff  = $signed({1'b0, target_q}) - $signed({1'b0, mag_q});
    assign adiff = diff[13] ? 14'(-diff) : 14'(diff);
    assign s     = (step_i == 6'd0) ? 6'd1 : step_i;

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        target_d  = target_q;
        mag_d     = mag_q;
        state_d   = state_q;
        clamped_d = 1'b0;

        // The tick always works against the target latched before this cycle
        if (state_q == RAMP && tick && !hold_i) begin
            if (adiff <= {8'd0, s}) begin
                mag_d   = target_q;
                state_d = IDLE;
            end else if (diff[13]) begin
                mag_d = mag_q - {7'd0, s};
            end else begin
                mag_d = mag_q + {7'd0, s};
            end
        end

        if (accept) begin
            target_d  = cmd_clamped;
            clamped_d = (cmd_clamped != cmd.cmd_target);
            state_d   = (cmd_clamped != mag_d) ? RAMP : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            target_q  <= INIT13;
            mag_q     <= INIT13;
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            mag_q     <= mag_d;
            state_q   <= state_d;
            ready_q   <= 1'b1;
            clamped_q <= clamped_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign magnitude_o   = mag_q;
    assign busy_o        = (state_q == RAMP);
    assign at_target_o   = (state_q == IDLE);
    assign clamped_o     = clamped_q;
endmodule

// File: tb/tb_servo_ramp.sv
// tb/tb_servo_ramp.sv - directed self-checking bench for servo_ramp
module tb_servo_ramp;
    logic        clk;
    logic        reset_n;
    logic [5:0]  step;
    logic        hold;
    logic [12:0] magnitude;
    logic        busy;
    logic        at_target;
    logic        clamped;

    int tests;
    int fails;
    int cnt_m;
    bit last_tick;

    servo_ramp_if bus ();

    servo_ramp #(
        .CLK_HZ   (1000),
        .UPDATE_HZ(100),
        .MAG_MIN  (1000),
        .MAG_MAX  (7000),
        .INIT_MAG (4096)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (bus.slave),
        .step_i     (step),
        .hold_i     (hold),
        .magnitude_o(magnitude),
        .busy_o     (busy),
        .at_target_o(at_target),
        .clamped_o  (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; keeps the bench's own model of the tick divider
    task automatic clk1();
        @(posedge clk);
        if (!reset_n) begin
            last_tick = 1'b0;
            cnt_m     = 0;
        end else begin
            last_tick = (cnt_m == 9);
            cnt_m     = (cnt_m == 9) ? 0 : cnt_m + 1;
        end
        #1;
    endtask

    task automatic next_tick();
        int n;
        n = 0;
        do begin
            clk1();
            n++;
        end while (!last_tick && n < 20);
        chk("tick_found", {31'd0, last_tick}, 32'd1);
    endtask

    task automatic to_pre_tick();
        int n;
        n = 0;
        while (cnt_m != 9 && n < 20) begin
            clk1();
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) clk1();
        reset_n = 1'b1;
        clk1();
    endtask

    task automatic send(input logic [12:0] t);
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = t;
        clk1();
        bus.cmd_valid  = 1'b0;
    endtask

    initial begin
        int  nt;
        bit  done;
        tests          = 0;
        fails          = 0;
        cnt_m          = 0;
        last_tick      = 1'b0;
        reset_n        = 1'b0;
        step           = 6'd16;
        hold           = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = 13'd0;

        // Reset state
        repeat (3) clk1();
        chk("rst_mag", 32'(magnitude), 32'd4096);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_at_target", 32'(at_target), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clamped", 32'(clamped), 32'd0);
        reset_n = 1'b1;
        clk1();
        chk("rel_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rel_mag", 32'(magnitude), 32'd4096);

        // Basic ramp, also confirms first tick lands on the tenth edge after release
        step = 6'd16;
        send(13'd4160);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_at_target", 32'(at_target), 32'd0);
        chk("basic_clamped", 32'(clamped), 32'd0);
        repeat (7) clk1();
        chk("pre_first_tick", 32'(magnitude), 32'd4096);
        clk1();
        chk("first_tick_edge", {31'd0, last_tick}, 32'd1);
        chk("basic_t1", 32'(magnitude), 32'd4112);
        next_tick(); chk("basic_t2", 32'(magnitude), 32'd4128);
        next_tick(); chk("basic_t3", 32'(magnitude), 32'd4144);
        chk("basic_busy_mid", 32'(busy), 32'd1);
        next_tick(); chk("basic_t4", 32'(magnitude), 32'd4160);
        chk("basic_done_at", 32'(at_target), 32'd1);
        chk("basic_done_busy", 32'(busy), 32'd0);

        // Final partial step, then step=0 behaves as 1
        do_reset();
        step = 6'd5;
        send(13'd4107);
        next_tick(); chk("p5_t1", 32'(magnitude), 32'd4101);
        next_tick(); chk("p5_t2", 32'(magnitude), 32'd4106);
        next_tick(); chk("p5_t3", 32'(magnitude), 32'd4107);
        chk("p5_at", 32'(at_target), 32'd1);
        step = 6'd0;
        send(13'd4104);
        next_tick(); chk("s0_t1", 32'(magnitude), 32'd4106);
        next_tick(); chk("s0_t2", 32'(magnitude), 32'd4105);
        next_tick(); chk("s0_t3", 32'(magnitude), 32'd4104);
        chk("s0_at", 32'(at_target), 32'd1);

        // Clamp high: 4104 -> 7000 at 63/tick is 45 full steps plus one of 61
        step = 6'd63;
        send(13'd8000);
        chk("clamp_pulse", 32'(clamped), 32'd1);
        clk1();
        chk("clamp_pulse_end", 32'(clamped), 32'd0);
        nt   = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            next_tick();
            nt++;
            if (magnitude > 13'd7000) chk("clamp_overshoot", 32'(magnitude), 32'd7000);
            if (at_target) done = 1'b1;
        end
        chk("clamp_ticks", 32'(nt), 32'd46);
        chk("clamp_final", 32'(magnitude), 32'd7000);

        // Clamp low
        send(13'd200);
        chk("clamp_low_pulse", 32'(clamped), 32'd1);
        chk("clamp_low_busy", 32'(busy), 32'd1);

        // Retarget in the same cycle as a tick
        do_reset();
        step = 6'd8;
        send(13'd5000);
        for (int i = 0; i < 13; i++) next_tick();
        chk("rt_start", 32'(magnitude), 32'd4200);
        to_pre_tick();
        step = 6'd32;
        send(13'd4100);
        chk("rt_same_edge", {31'd0, last_tick}, 32'd1);
        chk("rt_t0", 32'(magnitude), 32'd4232);
        chk("rt_clamped", 32'(clamped), 32'd0);
        next_tick(); chk("rt_t1", 32'(magnitude), 32'd4200);
        next_tick(); chk("rt_t2", 32'(magnitude), 32'd4168);
        next_tick(); chk("rt_t3", 32'(magnitude), 32'd4136);
        next_tick(); chk("rt_t4", 32'(magnitude), 32'd4104);
        next_tick(); chk("rt_t5", 32'(magnitude), 32'd4100);
        chk("rt_at", 32'(at_target), 32'd1);

        // Hold freezes magnitude but still accepts commands
        do_reset();
        step = 6'd4;
        send(13'd4200);
        next_tick();
        next_tick();
        chk("hold_pre", 32'(magnitude), 32'd4104);
        hold = 1'b1;
        repeat (25) clk1();
        send(13'd4300);
        repeat (24) clk1();
        chk("hold_mag", 32'(magnitude), 32'd4104);
        chk("hold_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        next_tick();
        chk("hold_resume", 32'(magnitude), 32'd4108);

        // Retarget to current magnitude returns to IDLE on the next edge
        send(13'd4108);
        chk("rt_eq_at", 32'(at_target), 32'd1);
        chk("rt_eq_mag", 32'(magnitude), 32'd4108);

        // Reset mid-ramp
        send(13'd4200);
        next_tick();
        chk("mid_mag", 32'(magnitude), 32'd4112);
        reset_n = 1'b0;
        clk1();
        chk("mid_rst_mag", 32'(magnitude), 32'd4096);
        chk("mid_rst_at", 32'(at_target), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        clk1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/servo_ramp.md
Name: servo_ramp

Overview:
- Slew-rate limiter placed directly upstream of the PWM servo driver.
- Accepts target position commands over a valid/ready handshake and clamps each target to a safe range.
- Steps its 13-bit `magnitude` output toward the target by at most `step` counts per update tick, so the servo never sees abrupt jumps.
- `magnitude` connects straight to the driver's magnitude input. Both blocks run on the same 50 MHz `clk`.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- UPDATE_HZ, 1000, ramp update rate. DIV = CLK_HZ/UPDATE_HZ, integer, must be ≥ 2.
- MAG_MIN, 0, lowest permitted magnitude.
- MAG_MAX, 8191, highest permitted magnitude. Requires MAG_MIN ≤ INIT_MAG ≤ MAG_MAX.
- INIT_MAG, 4096, magnitude and target after reset (servo centre).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  a target command is presented.
- cmd_target  in  13  requested position, unsigned.
- cmd_ready  out  1  block can accept a command.
- step  in  6  maximum change per tick. Value 0 is treated as 1.
- hold  in  1  freezes `magnitude` while high.
- magnitude  out  13  current position, feeds the servo driver.
- busy  out  1  ramp in progress.
- at_target  out  1  `magnitude` equals the latched target.
- clamped  out  1  one-cycle pulse: the last accepted command was out of range.

Behaviour:
- Reset is sampled on posedge `clk`. While `reset_n`=0:
  - tick counter=0; `target_q`=INIT_MAG; `magnitude`=INIT_MAG; state=IDLE;
  - `cmd_ready`=0, `busy`=0, `at_target`=1, `clamped`=0.
- Reset mid-ramp abandons the ramp: `magnitude` returns to INIT_MAG on the next edge.
- Tick divider:
  - Counter runs 0..DIV-1 and wraps to 0.
  - Internal `tick` is high for exactly one cycle when the counter equals DIV-1.
  - The first tick occurs DIV cycles after reset is released.
  - The divider runs regardless of state and of `hold`.
- Handshake:
  - `cmd_ready`=1 in every cycle after reset.
  - Accept occurs when `cmd_valid` & `cmd_ready`.
  - Accepted target, registered next edge: `target_q` = min(max(`cmd_target`, MAG_MIN), MAG_MAX).
  - `clamped` pulses high on that same edge for one cycle, only if clamping changed the value.
  - Accept in consecutive cycles is legal; the last accepted value wins.
- State machine:
  - IDLE: `magnitude`==`target_q`.
    - Go to RAMP on the edge after an accept whose clamped target ≠ `magnitude`.
    - An accept equal to `magnitude` stays in IDLE.
  - RAMP: on each cycle with `tick`=1 and `hold`=0, with `diff` = `target_q` − `magnitude` (14-bit signed) and `s` = (`step`==0 ? 1 : `step`):
    - if |`diff`| ≤ `s`: `magnitude` ← `target_q`, go to IDLE;
    - else: `magnitude` ← `magnitude` + sign(`diff`)·`s`.
  - `magnitude` changes only on tick edges in RAMP. It never overshoots and never leaves [MAG_MIN, MAG_MAX].
- Retarget mid-ramp:
  - The new `target_q` takes effect from the following tick.
  - Ramp direction may reverse.
  - A new target equal to the current `magnitude` returns the block to IDLE on the next edge.
- Simultaneous accept and tick in the same cycle: the tick uses the old `target_q`; the new target applies from the next tick.
- `hold`:
  - Ticks are ignored while `hold`=1.
  - `busy` stays 1 if the target is not yet reached.
  - Commands are still accepted.
  - `step` may change at any time and is sampled on the tick.
- Outputs are registered or pure state decodes:
  - `busy` = (state==RAMP).
  - `at_target` = (state==IDLE).

Test Plan:
- Bench settings: CLK_HZ=1000, UPDATE_HZ=100 (DIV=10).
- Reset/defaults: hold `reset_n`=0 for 3 cycles, then release → `magnitude`=4096, `at_target`=1, `busy`=0, `cmd_ready`=1; first `tick` at cycle 10 after release.
- Basic ramp: `step`=16, accept target 4160 → `busy`=1; `magnitude` 4112, 4128, 4144, 4160 on 4 successive ticks; then `at_target`=1, `busy`=0.
- Final partial step / step=0:
  - `step`=5, target 4107 from 4096 → 4101, 4106, 4107.
  - `step`=0, target 4104 from 4107 → 4106, 4105, 4104.
- Clamp: MAG_MIN=1000, MAG_MAX=7000, `step`=63, accept 8000 → `clamped` pulses 1 cycle; `magnitude` stops exactly at 7000, never above.
- Retarget and simultaneous event: mid-ramp toward 5000 at `magnitude` 4200, accept 4100 in the same cycle as a tick with `step`=32 → that tick gives 4232; following ticks give 4200, 4168, 4136, 4104, 4100.
- Hold and reset mid-ramp:
  - `hold`=1 for 50 cycles while `busy` → `magnitude` constant, `busy`=1.
  - Release `hold` → ramp resumes at the next tick.
  - Assert `reset_n`=0 mid-ramp → next edge gives `magnitude`=4096, IDLE.
